// File: rtl/idma_multi_ch_event_ctrl.sv
// Per-channel iDMA event tracker: outstanding count, done-IRQ coalescing, error capture, IDLE/ACTIVE/ERROR FSM.
// Optional IDMA_EVT_IDLE_FLUSH_EN: a channel going ACTIVE->IDLE flushes a partial coalescing batch as a done IRQ.
module idma_multi_ch_event_ctrl #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned COAL_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        start_i,
  input  logic [NUM_CH-1:0]        done_i,
  input  logic [NUM_CH-1:0]        error_i,
  input  logic [NUM_CH-1:0]        busy_i,
  input  logic [NUM_CH-1:0]        irq_en_i,
  input  logic [NUM_CH*COAL_W-1:0] coal_thr_i,
  input  logic [NUM_CH-1:0]        clr_i,
  output logic [NUM_CH*CNT_W-1:0]  outstanding_o,
  output logic [NUM_CH-1:0]        done_irq_o,
  output logic [NUM_CH-1:0]        err_irq_o,
  output logic [NUM_CH-1:0]        idle_o,
  output logic                     any_irq_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_ERROR  = 2'd2;

  logic [NUM_CH-1:0] done_sticky;
  logic [NUM_CH-1:0] err_sticky;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]        st_q, st_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [COAL_W-1:0] coal_q, coal_n;
    logic              done_q, done_n;
    logic              err_q, err_n;
    logic [COAL_W-1:0] thr_eff;
    logic [COAL_W:0]   coal_inc;
    logic              inc, dec, ovf, udf;
    logic              err_set, done_set;

    assign thr_eff  = (coal_thr_i[i*COAL_W +: COAL_W] == '0) ? COAL_W'(1)
                                                             : coal_thr_i[i*COAL_W +: COAL_W];
    assign coal_inc = {1'b0, coal_q} + (COAL_W+1)'(1);

    always_comb begin
      inc      = start_i[i] & ~done_i[i];
      dec      = done_i[i] & ~start_i[i];
      ovf      = inc && (cnt_q == '1);
      udf      = dec && (cnt_q == '0);
      err_set  = error_i[i] | ovf | udf;
      done_set = 1'b0;

      cnt_n = cnt_q;
      if (inc && !ovf)
        cnt_n = cnt_q + CNT_W'(1);
      else if (dec && !udf)
        cnt_n = cnt_q - CNT_W'(1);

      // ">=" rather than "==" so a lowered threshold fires on the next done
      coal_n = coal_q;
      if (done_i[i]) begin
        if (coal_inc >= {1'b0, thr_eff}) begin
          coal_n   = '0;
          done_set = 1'b1;
        end else begin
          coal_n = coal_inc[COAL_W-1:0];
        end
      end
      if (clr_i[i])
        coal_n = '0;

      st_n = st_q;
      if (err_set) begin
        st_n = ST_ERROR;
      end else begin
        case (st_q)
          ST_IDLE:   if (cnt_n != '0) st_n = ST_ACTIVE;
          ST_ACTIVE: if (cnt_n == '0 && !busy_i[i]) st_n = ST_IDLE;
          ST_ERROR:  if (clr_i[i]) st_n = (cnt_n == '0 && !busy_i[i]) ? ST_IDLE : ST_ACTIVE;
          default:   st_n = ST_IDLE;
        endcase
      end

`ifdef IDMA_EVT_IDLE_FLUSH_EN
      if (st_q == ST_ACTIVE && st_n == ST_IDLE && coal_n != '0) begin
        coal_n   = '0;
        done_set = 1'b1;
      end
`endif

      // Set events take priority over the acknowledge
      done_n = done_set ? 1'b1 : (clr_i[i] ? 1'b0 : done_q);
      err_n  = err_set  ? 1'b1 : (clr_i[i] ? 1'b0 : err_q);
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        st_q   <= ST_IDLE;
        cnt_q  <= '0;
        coal_q <= '0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        st_q   <= st_n;
        cnt_q  <= cnt_n;
        coal_q <= coal_n;
        done_q <= done_n;
        err_q  <= err_n;
      end
    end

    assign outstanding_o[i*CNT_W +: CNT_W] = cnt_q;
    assign idle_o[i]      = (st_q == ST_IDLE);
    assign done_sticky[i] = done_q;
    assign err_sticky[i]  = err_q;
  end

  assign done_irq_o = done_sticky & irq_en_i;
  assign err_irq_o  = err_sticky & irq_en_i;
  assign any_irq_o  = |(done_irq_o | err_irq_o);

endmodule

// File: tb/tb_idma_multi_ch_event_ctrl.sv
// Directed bench for idma_multi_ch_event_ctrl: main instance (CNT_W=8) plus a CNT_W=2 instance for overflow.
module tb_idma_multi_ch_event_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  start = '0, done = '0, error = '0, busy = '0, irq_en = '1, clr = '0;
  logic [7:0]  coal_thr = '0;
  logic [15:0] outstanding;
  logic [1:0]  done_irq, err_irq, idle;
  logic        any_irq;
  logic [3:0]  outstanding_w2;
  logic [1:0]  done_irq_w2, err_irq_w2, idle_w2;
  logic        any_irq_w2;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  idma_multi_ch_event_ctrl #(.NUM_CH(2), .CNT_W(8), .COAL_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .done_i(done), .error_i(error),
    .busy_i(busy), .irq_en_i(irq_en), .coal_thr_i(coal_thr), .clr_i(clr),
    .outstanding_o(outstanding), .done_irq_o(done_irq), .err_irq_o(err_irq),
    .idle_o(idle), .any_irq_o(any_irq));

  idma_multi_ch_event_ctrl #(.NUM_CH(2), .CNT_W(2), .COAL_W(4)) dut_w2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .done_i(done), .error_i(error),
    .busy_i(busy), .irq_en_i(irq_en), .coal_thr_i(coal_thr), .clr_i(clr),
    .outstanding_o(outstanding_w2), .done_irq_o(done_irq_w2), .err_irq_o(err_irq_w2),
    .idle_o(idle_w2), .any_irq_o(any_irq_w2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] s, input logic [1:0] d, input logic [1:0] e, input logic [1:0] c);
    start = s; done = d; error = e; clr = c;
    step();
    start = '0; done = '0; error = '0; clr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 2'b11; error = 2'b11;
    step();
    rst = 1'b0; start = '0; error = '0;
    n_cmp++; if (outstanding !== 16'h0) begin n_fail++; $display("FAIL rst_outstanding got %h want 0000", outstanding); end
    n_cmp++; if (done_irq !== 2'b00) begin n_fail++; $display("FAIL rst_done_irq got %b want 00", done_irq); end
    n_cmp++; if (err_irq !== 2'b00) begin n_fail++; $display("FAIL rst_err_irq got %b want 00", err_irq); end
    n_cmp++; if (idle !== 2'b11) begin n_fail++; $display("FAIL rst_idle got %b want 11", idle); end
    n_cmp++; if (any_irq !== 1'b0) begin n_fail++; $display("FAIL rst_any_irq got %b want 0", any_irq); end
  endtask

  task automatic test_coalesce();
    do_reset();
    coal_thr = {4'd0, 4'd3};
    for (int k = 0; k < 3; k++) pulse(2'b01, 2'b00, 2'b00, 2'b00);
    n_cmp++; if (outstanding[7:0] !== 8'd3) begin n_fail++; $display("FAIL coal_cnt3 got %0d want 3", outstanding[7:0]); end
    n_cmp++; if (idle !== 2'b10) begin n_fail++; $display("FAIL coal_idle_active got %b want 10", idle); end
    for (int k = 0; k < 2; k++) pulse(2'b00, 2'b01, 2'b00, 2'b00);
    n_cmp++; if (done_irq !== 2'b00) begin n_fail++; $display("FAIL coal_early got %b want 00", done_irq); end
    pulse(2'b00, 2'b01, 2'b00, 2'b00);
    n_cmp++; if (done_irq !== 2'b01) begin n_fail++; $display("FAIL coal_fire got %b want 01", done_irq); end
    n_cmp++; if (outstanding !== 16'h0000) begin n_fail++; $display("FAIL coal_cnt0 got %h want 0000", outstanding); end
    n_cmp++; if (idle !== 2'b11) begin n_fail++; $display("FAIL coal_idle got %b want 11", idle); end
    n_cmp++; if (any_irq !== 1'b1) begin n_fail++; $display("FAIL coal_any got %b want 1", any_irq); end
    pulse(2'b00, 2'b00, 2'b00, 2'b01);
    n_cmp++; if (done_irq !== 2'b00) begin n_fail++; $display("FAIL coal_clr got %b want 00", done_irq); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    coal_thr = {4'd0, 4'd3};
    for (int k = 0; k < 5; k++) pulse(2'b01, 2'b00, 2'b00, 2'b00);
    pulse(2'b01, 2'b01, 2'b00, 2'b00);
    n_cmp++; if (outstanding[7:0] !== 8'd5) begin n_fail++; $display("FAIL simul_cnt got %0d want 5", outstanding[7:0]); end
    pulse(2'b00, 2'b01, 2'b00, 2'b00);
    n_cmp++; if (done_irq !== 2'b00) begin n_fail++; $display("FAIL simul_coal2 got %b want 00", done_irq); end
    pulse(2'b00, 2'b01, 2'b00, 2'b00);
    n_cmp++; if (done_irq !== 2'b01) begin n_fail++; $display("FAIL simul_coal3 got %b want 01", done_irq); end
    n_cmp++; if (outstanding[7:0] !== 8'd3) begin n_fail++; $display("FAIL simul_cnt3 got %0d want 3", outstanding[7:0]); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 3; k++) pulse(2'b01, 2'b00, 2'b00, 2'b00);
    n_cmp++; if (err_irq_w2 !== 2'b00) begin n_fail++; $display("FAIL ovf_early got %b want 00", err_irq_w2); end
    pulse(2'b01, 2'b00, 2'b00, 2'b00);
    n_cmp++; if (outstanding_w2 !== 4'b0011) begin n_fail++; $display("FAIL ovf_hold got %b want 0011", outstanding_w2); end
    n_cmp++; if (err_irq_w2 !== 2'b01) begin n_fail++; $display("FAIL ovf_err got %b want 01", err_irq_w2); end
    n_cmp++; if (idle_w2 !== 2'b10) begin n_fail++; $display("FAIL ovf_idle got %b want 10", idle_w2); end
    n_cmp++; if (outstanding[7:0] !== 8'd4 || err_irq !== 2'b00) begin n_fail++; $display("FAIL ovf_wide got %0d/%b want 4/00", outstanding[7:0], err_irq); end
    pulse(2'b00, 2'b00, 2'b00, 2'b01);
    n_cmp++; if (err_irq_w2 !== 2'b00 || idle_w2 !== 2'b10) begin n_fail++; $display("FAIL ovf_clr got err %b idle %b want 00/10", err_irq_w2, idle_w2); end
    for (int k = 0; k < 3; k++) pulse(2'b00, 2'b01, 2'b00, 2'b00);
    n_cmp++; if (outstanding_w2 !== 4'b0000 || idle_w2 !== 2'b11) begin n_fail++; $display("FAIL ovf_active_idle got cnt %b idle %b want 0000/11", outstanding_w2, idle_w2); end
  endtask

  task automatic test_underflow();
    do_reset();
    coal_thr = {4'd0, 4'd3};
    pulse(2'b00, 2'b01, 2'b00, 2'b00);
    n_cmp++; if (outstanding[7:0] !== 8'd0) begin n_fail++; $display("FAIL udf_hold got %0d want 0", outstanding[7:0]); end
    n_cmp++; if (err_irq !== 2'b01 || idle !== 2'b10) begin n_fail++; $display("FAIL udf_err got err %b idle %b want 01/10", err_irq, idle); end
    pulse(2'b00, 2'b00, 2'b01, 2'b01);
    n_cmp++; if (err_irq !== 2'b01) begin n_fail++; $display("FAIL udf_set_wins got %b want 01", err_irq); end
    pulse(2'b00, 2'b00, 2'b00, 2'b01);
    n_cmp++; if (err_irq !== 2'b00 || idle !== 2'b11) begin n_fail++; $display("FAIL udf_clr got err %b idle %b want 00/11", err_irq, idle); end
  endtask

  task automatic test_mask();
    do_reset();
    coal_thr = {4'd0, 4'd3};
    irq_en = 2'b00;
    pulse(2'b10, 2'b00, 2'b00, 2'b00);
    pulse(2'b00, 2'b10, 2'b00, 2'b00);
    n_cmp++; if (done_irq !== 2'b00 || any_irq !== 1'b0) begin n_fail++; $display("FAIL mask_off got %b/%b want 00/0", done_irq, any_irq); end
    irq_en = 2'b11;
    #1;
    n_cmp++; if (done_irq !== 2'b10 || any_irq !== 1'b1) begin n_fail++; $display("FAIL mask_on got %b/%b want 10/1", done_irq, any_irq); end
    pulse(2'b00, 2'b00, 2'b00, 2'b10);
  endtask

  task automatic test_busy();
    do_reset();
    pulse(2'b01, 2'b00, 2'b00, 2'b00);
    busy = 2'b01;
    pulse(2'b00, 2'b01, 2'b00, 2'b00);
    n_cmp++; if (outstanding[7:0] !== 8'd0 || idle !== 2'b10) begin n_fail++; $display("FAIL busy_hold got cnt %0d idle %b want 0/10", outstanding[7:0], idle); end
    busy = 2'b00;
    step();
    n_cmp++; if (idle !== 2'b11) begin n_fail++; $display("FAIL busy_release got %b want 11", idle); end
  endtask

  task automatic test_thr_change();
    do_reset();
    coal_thr = {4'd0, 4'd4};
    for (int k = 0; k < 3; k++) pulse(2'b01, 2'b01, 2'b00, 2'b00);
    n_cmp++; if (done_irq !== 2'b00 || outstanding[7:0] !== 8'd0) begin n_fail++; $display("FAIL thr_pre got %b/%0d want 00/0", done_irq, outstanding[7:0]); end
    coal_thr = {4'd0, 4'd2};
    pulse(2'b01, 2'b01, 2'b00, 2'b00);
    n_cmp++; if (done_irq !== 2'b01) begin n_fail++; $display("FAIL thr_lowered got %b want 01", done_irq); end
  endtask

  task automatic test_flush();
    do_reset();
    coal_thr = {4'd0, 4'd4};
    for (int k = 0; k < 2; k++) pulse(2'b01, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 2; k++) pulse(2'b00, 2'b01, 2'b00, 2'b00);
    n_cmp++; if (idle !== 2'b11) begin n_fail++; $display("FAIL flush_idle got %b want 11", idle); end
`ifdef IDMA_EVT_IDLE_FLUSH_EN
    n_cmp++; if (done_irq !== 2'b01) begin n_fail++; $display("FAIL flush_fire got %b want 01", done_irq); end
    pulse(2'b00, 2'b00, 2'b00, 2'b01);
    for (int k = 0; k < 2; k++) pulse(2'b01, 2'b01, 2'b00, 2'b00);
    n_cmp++; if (done_irq !== 2'b00) begin n_fail++; $display("FAIL flush_zeroed got %b want 00", done_irq); end
`else
    n_cmp++; if (done_irq !== 2'b00) begin n_fail++; $display("FAIL noflush got %b want 00", done_irq); end
    for (int k = 0; k < 2; k++) pulse(2'b01, 2'b01, 2'b00, 2'b00);
    n_cmp++; if (done_irq !== 2'b01) begin n_fail++; $display("FAIL noflush_kept got %b want 01", done_irq); end
`endif
  endtask

  initial begin
    test_reset();
    test_coalesce();
    test_simultaneous();
    test_overflow();
    test_underflow();
    test_mask();
    test_busy();
    test_thr_change();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
